// File: rtl/mem_arbiter.sv
// Byte-wide memory/IO port arbiter between instruction fetch and the load/store buffer.
// Serialises word/half/byte requests into consecutive little-endian byte accesses.
module mem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter logic [1:0]  IO_SEL     = 2'b11
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  clear,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_done,
  output logic [31:0]           if_data,
  input  logic                  lsb_req,
  input  logic                  lsb_wr,
  input  logic [1:0]            lsb_size,
  input  logic [ADDR_WIDTH-1:0] lsb_addr,
  input  logic [31:0]           lsb_wdata,
  output logic                  lsb_done,
  output logic [31:0]           lsb_rdata,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr,
  input  logic                  io_buffer_full,
  output logic                  busy
);

  typedef enum logic [2:0] {IDLE, IF_RD, LSB_RD, LSB_WR, RESP} state_t;

  state_t                  state, state_nx;
  logic                    last_lsb;
  logic [ADDR_WIDTH-1:0]   base;
  logic [2:0]              cnt, issue, cap, lsb_n, off;
  logic [31:0]             wdata, data;
  logic                    pend, paused;
  logic                    rd, io_stall, capture, last_cap, grant, pick_lsb;

  assign rd       = (state == IF_RD) || (state == LSB_RD);
  assign io_stall = (base[17:16] == IO_SEL) && io_buffer_full;
  assign capture  = rd && rdy_in && !paused && pend;
  assign last_cap = capture && (cap == cnt - 3'd1);
  assign pick_lsb = lsb_req && (!if_req || !last_lsb);
  assign grant    = (state == IDLE) && rdy_in && !clear && (if_req || lsb_req);
  assign busy     = (state != IDLE);
  // While paused (and on the resume cycle) the bus shows the oldest uncaptured byte.
  assign off      = (paused || !rdy_in || (issue >= cnt)) ? cap : issue;

  always_comb begin
    case (lsb_size)
      2'd0:    lsb_n = 3'd1;
      2'd1:    lsb_n = 3'd2;
      default: lsb_n = 3'd4;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    if_done   = 1'b0;
    if_data   = '0;
    lsb_done  = 1'b0;
    lsb_rdata = '0;
    mem_a     = '0;
    mem_dout  = '0;
    mem_wr    = 1'b0;
    case (state)
      IDLE: begin
        if (grant) state_nx = pick_lsb ? (lsb_wr ? LSB_WR : LSB_RD) : IF_RD;
      end
      IF_RD, LSB_RD: begin
        mem_a = base + ADDR_WIDTH'(off);
        if (rdy_in && clear && (state == IF_RD)) state_nx = IDLE;
        else if (last_cap)                      state_nx = RESP;
      end
      LSB_WR: begin
        mem_a = base + ADDR_WIDTH'(issue);
        if (issue < cnt) begin
          mem_dout = wdata[{issue[1:0], 3'b000} +: 8];
          mem_wr   = rdy_in && !io_stall;
        end else if (rdy_in) begin
          state_nx = RESP;
        end
      end
      RESP: begin
        if (last_lsb) begin
          lsb_done  = 1'b1;
          lsb_rdata = data;
        end else begin
          if_done = !clear;
          if_data = data;
        end
        if (rdy_in) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      last_lsb <= 1'b0;
      base     <= '0;
      cnt      <= '0;
      issue    <= '0;
      cap      <= '0;
      wdata    <= '0;
      data     <= '0;
      pend     <= 1'b0;
      paused   <= 1'b0;
    end else if (!rdy_in) begin
      paused <= 1'b1;
    end else begin
      paused <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            last_lsb <= pick_lsb;
            base     <= pick_lsb ? lsb_addr : if_addr;
            cnt      <= pick_lsb ? lsb_n : 3'd4;
            wdata    <= lsb_wdata;
            data     <= '0;
            issue    <= '0;
            cap      <= '0;
            pend     <= 1'b0;
          end
        end
        IF_RD, LSB_RD: begin
          if (paused) begin
            // Resume: re-fetch the oldest uncaptured byte; its stale read is discarded.
            issue <= cap + 3'd1;
            pend  <= 1'b1;
          end else begin
            pend <= (issue < cnt);
            if (issue < cnt) issue <= issue + 3'd1;
            if (capture) begin
              data[{cap[1:0], 3'b000} +: 8] <= mem_din;
              cap <= cap + 3'd1;
            end
          end
        end
        LSB_WR: begin
          if ((issue < cnt) && !io_stall) issue <= issue + 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: byte-addressed memory model plus per-scenario checks.
module tb_mem_arbiter;

  logic        clk_in, rst_in, rdy_in, clear;
  logic        if_req, if_done;
  logic [31:0] if_addr, if_data;
  logic        lsb_req, lsb_wr, lsb_done;
  logic [1:0]  lsb_size;
  logic [31:0] lsb_addr, lsb_wdata, lsb_rdata;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr, io_buffer_full, busy;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned wr_count = 0;
  logic [7:0]  mem [0:65535];

  mem_arbiter #(.ADDR_WIDTH(32), .IO_SEL(2'b11)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .lsb_req(lsb_req), .lsb_wr(lsb_wr), .lsb_size(lsb_size), .lsb_addr(lsb_addr),
    .lsb_wdata(lsb_wdata), .lsb_done(lsb_done), .lsb_rdata(lsb_rdata),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full), .busy(busy)
  );

  always #5 clk_in = ~clk_in;

  // One-cycle read latency memory, indexed by the low 16 address bits.
  always @(posedge clk_in) mem_din <= mem[mem_a[15:0]];
  always @(posedge clk_in) begin
    if (mem_wr) begin
      mem[mem_a[15:0]] <= mem_dout;
      wr_count <= wr_count + 1;
    end
  end

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset;
    #3;
    checks++;
    if ({if_done, lsb_done, mem_wr, busy} !== 4'b0 || mem_a !== 32'h0 || mem_dout !== 8'h0 ||
        if_data !== 32'h0 || lsb_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: done=%b/%b wr=%b busy=%b a=%h dout=%h, required all 0",
               if_done, lsb_done, mem_wr, busy, mem_a, mem_dout);
    end
    tick; tick;
    rst_in = 1'b1;
    tick;
    checks++;
    if (busy !== 1'b0 || mem_a !== 32'h0) begin
      errors++;
      $display("FAIL reset_release: busy=%b a=%h, required 0/0", busy, mem_a);
    end
  endtask

  task automatic test_fetch;
    if_addr = 32'h100; if_req = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick;
      if (k <= 4) begin
        checks++;
        if (mem_a !== 32'h100 + 32'(k - 1) || mem_wr !== 1'b0) begin
          errors++;
          $display("FAIL fetch_addr T+%0d: a=%h wr=%b, required %h/0", k, mem_a, mem_wr, 32'h100 + 32'(k - 1));
        end
      end
      checks++;
      if (k < 6 && if_done !== 1'b0) begin
        errors++;
        $display("FAIL fetch_early_done T+%0d: if_done=%b, required 0", k, if_done);
      end else if (k == 6 && (if_done !== 1'b1 || if_data !== 32'h00100513)) begin
        errors++;
        $display("FAIL fetch_done: if_done=%b data=%h, required 1/00100513", if_done, if_data);
      end
    end
    tick;
    if_req = 1'b0;
    checks++;
    if (if_done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL fetch_idle: if_done=%b busy=%b, required 0/0", if_done, busy);
    end
  endtask

  task automatic test_arbitration;
    if_req = 1'b1; if_addr = 32'h100;
    lsb_req = 1'b1; lsb_wr = 1'b0; lsb_size = 2'd0; lsb_addr = 32'h2000;
    tick;
    checks++;
    if (mem_a !== 32'h2000) begin
      errors++;
      $display("FAIL arb_lsb_first: a=%h, required 00002000", mem_a);
    end
    tick; tick;
    checks++;
    if (lsb_done !== 1'b1 || lsb_rdata !== 32'h5A || if_done !== 1'b0) begin
      errors++;
      $display("FAIL arb_lsb_done: done=%b rdata=%h if_done=%b, required 1/0000005a/0", lsb_done, lsb_rdata, if_done);
    end
    tick;
    lsb_addr = 32'h2001;
    tick;
    checks++;
    if (mem_a !== 32'h100) begin
      errors++;
      $display("FAIL arb_if_wins: a=%h, required 00000100", mem_a);
    end
    for (int k = 6; k <= 10; k++) tick;
    checks++;
    if (if_done !== 1'b1 || if_data !== 32'h00100513) begin
      errors++;
      $display("FAIL arb_if_done: if_done=%b data=%h, required 1/00100513", if_done, if_data);
    end
    tick;
    if_req = 1'b0;
    tick;
    checks++;
    if (mem_a !== 32'h2001) begin
      errors++;
      $display("FAIL arb_lsb_second: a=%h, required 00002001", mem_a);
    end
    tick; tick;
    checks++;
    if (lsb_done !== 1'b1 || lsb_rdata !== 32'hA5) begin
      errors++;
      $display("FAIL arb_lsb2_done: done=%b rdata=%h, required 1/000000a5", lsb_done, lsb_rdata);
    end
    tick;
    lsb_req = 1'b0;
  endtask

  task automatic test_io_backpressure;
    int unsigned w0;
    w0 = wr_count;
    lsb_req = 1'b1; lsb_wr = 1'b1; lsb_size = 2'd0; lsb_addr = 32'h30000; lsb_wdata = 32'h41;
    io_buffer_full = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick;
      checks++;
      if (mem_wr !== 1'b0 || mem_a !== 32'h30000) begin
        errors++;
        $display("FAIL io_hold T+%0d: wr=%b a=%h, required 0/00030000", k, mem_wr, mem_a);
      end
    end
    tick;
    io_buffer_full = 1'b0;
    #1;
    checks++;
    if (mem_wr !== 1'b1 || mem_a !== 32'h30000 || mem_dout !== 8'h41) begin
      errors++;
      $display("FAIL io_write: wr=%b a=%h dout=%h, required 1/00030000/41", mem_wr, mem_a, mem_dout);
    end
    tick;
    checks++;
    if (mem_wr !== 1'b0 || lsb_done !== 1'b0) begin
      errors++;
      $display("FAIL io_after_write: wr=%b done=%b, required 0/0", mem_wr, lsb_done);
    end
    tick;
    checks++;
    if (lsb_done !== 1'b1 || wr_count - w0 != 1 || mem[16'h0000] !== 8'h41) begin
      errors++;
      $display("FAIL io_done: done=%b writes=%0d byte=%h, required 1/1/41", lsb_done, wr_count - w0, mem[16'h0000]);
    end
    tick;
    lsb_req = 1'b0; lsb_wr = 1'b0;
  endtask

  task automatic test_pause;
    lsb_req = 1'b1; lsb_wr = 1'b0; lsb_size = 2'd2; lsb_addr = 32'h400;
    for (int k = 1; k <= 9; k++) begin
      tick;
      if (k == 3) begin
        rdy_in = 1'b0;
        #1;
        checks++;
        if (mem_a !== 32'h401) begin
          errors++;
          $display("FAIL pause_addr: a=%h, required 00000401", mem_a);
        end
      end
      if (k == 5) rdy_in = 1'b1;
      checks++;
      if (mem_wr !== 1'b0) begin
        errors++;
        $display("FAIL pause_wr T+%0d: wr=%b, required 0", k, mem_wr);
      end
      checks++;
      if (k < 9 && lsb_done !== 1'b0) begin
        errors++;
        $display("FAIL pause_early_done T+%0d: done=%b, required 0", k, lsb_done);
      end else if (k == 9 && (lsb_done !== 1'b1 || lsb_rdata !== 32'hDEADBEEF)) begin
        errors++;
        $display("FAIL pause_done: done=%b rdata=%h, required 1/deadbeef", lsb_done, lsb_rdata);
      end
    end
    rdy_in = 1'b0;
    tick;
    lsb_req = 1'b0;
    checks++;
    if (lsb_done !== 1'b1 || lsb_rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL pause_done_extend: done=%b rdata=%h, required 1/deadbeef", lsb_done, lsb_rdata);
    end
    rdy_in = 1'b1;
    tick;
    checks++;
    if (lsb_done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL pause_idle: done=%b busy=%b, required 0/0", lsb_done, busy);
    end
  endtask

  task automatic test_clear;
    int unsigned w0;
    if_req = 1'b1; if_addr = 32'h100;
    tick; tick;
    clear = 1'b1; if_req = 1'b0;
    tick;
    clear = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL clear_if_idle: busy=%b, required 0", busy);
    end
    for (int k = 3; k <= 8; k++) begin
      checks++;
      if (if_done !== 1'b0) begin
        errors++;
        $display("FAIL clear_if_done T+%0d: if_done=%b, required 0", k, if_done);
      end
      tick;
    end
    if_req = 1'b1;
    for (int k = 1; k <= 6; k++) tick;
    clear = 1'b1;
    #1;
    checks++;
    if (if_done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL clear_resp: if_done=%b busy=%b, required 0/1", if_done, busy);
    end
    tick;
    clear = 1'b0; if_req = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL clear_resp_idle: busy=%b, required 0", busy);
    end
    w0 = wr_count;
    lsb_req = 1'b1; lsb_wr = 1'b1; lsb_size = 2'd1; lsb_addr = 32'h10; lsb_wdata = 32'hBEEF;
    tick;
    clear = 1'b1;
    #1;
    checks++;
    if (mem_wr !== 1'b1 || mem_a !== 32'h10 || mem_dout !== 8'hEF) begin
      errors++;
      $display("FAIL clear_wr_b0: wr=%b a=%h dout=%h, required 1/00000010/ef", mem_wr, mem_a, mem_dout);
    end
    clear = 1'b0;
    tick;
    checks++;
    if (mem_wr !== 1'b1 || mem_a !== 32'h11 || mem_dout !== 8'hBE) begin
      errors++;
      $display("FAIL clear_wr_b1: wr=%b a=%h dout=%h, required 1/00000011/be", mem_wr, mem_a, mem_dout);
    end
    tick;
    tick;
    clear = 1'b1;
    #1;
    checks++;
    if (lsb_done !== 1'b1) begin
      errors++;
      $display("FAIL clear_wr_done: done=%b, required 1", lsb_done);
    end
    clear = 1'b0;
    tick;
    lsb_req = 1'b0; lsb_wr = 1'b0;
    checks++;
    if (wr_count - w0 != 2 || mem[16'h0010] !== 8'hEF || mem[16'h0011] !== 8'hBE) begin
      errors++;
      $display("FAIL clear_wr_mem: writes=%0d bytes=%h %h, required 2/ef be", wr_count - w0, mem[16'h0010], mem[16'h0011]);
    end
  endtask

  task automatic test_reset_mid;
    lsb_req = 1'b1; lsb_wr = 1'b1; lsb_size = 2'd2; lsb_addr = 32'h20; lsb_wdata = 32'h11223344;
    tick;
    checks++;
    if (mem_wr !== 1'b1 || mem_dout !== 8'h44) begin
      errors++;
      $display("FAIL rst_mid_pre: wr=%b dout=%h, required 1/44", mem_wr, mem_dout);
    end
    tick;
    rst_in = 1'b0;
    #1;
    checks++;
    if (mem_wr !== 1'b0 || mem_a !== 32'h0 || mem_dout !== 8'h0 || busy !== 1'b0 || lsb_done !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_async: wr=%b a=%h dout=%h busy=%b done=%b, required all 0",
               mem_wr, mem_a, mem_dout, busy, lsb_done);
    end
    lsb_req = 1'b0; lsb_wr = 1'b0;
    tick; tick;
    rst_in = 1'b1;
    tick;
    checks++;
    if (busy !== 1'b0 || mem_a !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid_idle: busy=%b a=%h, required 0/0", busy, mem_a);
    end
    if_req = 1'b1; if_addr = 32'h100;
    lsb_req = 1'b1; lsb_size = 2'd0; lsb_addr = 32'h2000;
    tick;
    checks++;
    if (mem_a !== 32'h2000) begin
      errors++;
      $display("FAIL rst_last_grant: a=%h, required 00002000", mem_a);
    end
    tick; tick;
    checks++;
    if (lsb_done !== 1'b1 || lsb_rdata !== 32'h5A) begin
      errors++;
      $display("FAIL rst_lsb_done: done=%b rdata=%h, required 1/0000005a", lsb_done, lsb_rdata);
    end
    tick;
    if_req = 1'b0; lsb_req = 1'b0;
    tick; tick;
  endtask

  initial begin
    clk_in = 1'b0; rst_in = 1'b0; rdy_in = 1'b1; clear = 1'b0;
    if_req = 1'b0; if_addr = '0;
    lsb_req = 1'b0; lsb_wr = 1'b0; lsb_size = '0; lsb_addr = '0; lsb_wdata = '0;
    io_buffer_full = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0100] = 8'h13; mem[16'h0101] = 8'h05; mem[16'h0102] = 8'h10; mem[16'h0103] = 8'h00;
    mem[16'h2000] = 8'h5A; mem[16'h2001] = 8'hA5;
    mem[16'h0400] = 8'hEF; mem[16'h0401] = 8'hBE; mem[16'h0402] = 8'hAD; mem[16'h0403] = 8'hDE;
    test_reset;
    test_fetch;
    test_arbitration;
    test_io_backpressure;
    test_pause;
    test_clear;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Owns the single byte-wide memory/IO port of the CPU and shares it between instruction fetch (IF) and the load/store buffer (LSB).
- Accepts whole-word fetch requests and 1/2/4-byte load/store requests, then sequences them as consecutive byte accesses with little-endian assembly.
- Handles the one-cycle read latency, UART back-pressure, the rdy_in pause and misprediction clear.
- Replaces the combinational IF/LSB bus mux at CPU top.

Parameters:
- ADDR_WIDTH, 32, width of request and memory addresses.
- IO_SEL, 2'b11, value of addr[17:16] that marks the IO region.

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  reset
- rdy_in  in  1  global ready; low pauses the block
- clear  in  1  misprediction flush
- if_req  in  1  IF word-fetch request
- if_addr  in  32  IF fetch address
- if_done  out  1  one-cycle pulse; if_data valid
- if_data  out  32  fetched word
- lsb_req  in  1  LSB request
- lsb_wr  in  1  1 = store, 0 = load
- lsb_size  in  2  0 = byte, 1 = half, 2 = word (3 treated as word)
- lsb_addr  in  32  LSB address
- lsb_wdata  in  32  store data
- lsb_done  out  1  one-cycle pulse; store complete or lsb_rdata valid
- lsb_rdata  out  32  load data, zero-extended
- mem_din  in  8  memory read data (valid the cycle after its address)
- mem_dout  out  8  memory write data
- mem_a  out  32  memory address
- mem_wr  out  1  1 = write
- io_buffer_full  in  1  UART TX buffer full
- busy  out  1  high in any state other than IDLE

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low. While rst_in is low:
  - state = IDLE; counters = 0; last_grant = IF.
  - All outputs are 0, including mem_a, mem_wr, done pulses and data outputs.
- States: IDLE, IF_RD, LSB_RD, LSB_WR, RESP.
- Arbitration (IDLE only, registered):
  - If exactly one request is high, that requester is granted at the clock edge.
  - If both are high, the requester not in last_grant wins; last_grant is updated on every grant.
  - Once granted, a transaction is never preempted.
- Byte count n: IF = 4; LSB = 1, 2 or 4 according to lsb_size. Address, size and data are latched at grant.
- Reads (IF_RD, LSB_RD):
  - Issue pointer i drives mem_a = base + i in bus cycles 0..n-1, with mem_wr = 0.
  - Byte i is captured from mem_din at the end of bus cycle i+1 into bits [8i+7:8i].
  - After byte n-1 is captured, go to RESP.
- Writes (LSB_WR):
  - Bus cycle i drives mem_a = base + i, mem_dout = wdata[8i+7:8i], mem_wr = 1.
  - After byte n-1 is written, go to RESP.
- RESP: lasts one cycle. The granted requester's done output is high and its data output holds the assembled value; all requests are ignored; next state is IDLE. Requesters deassert req in the cycle after seeing done.
- Latency from the request cycle (T) with no stalls:
  - 4-byte read: done in T+6.
  - 1-byte read: done in T+3.
  - n-byte write: done in T+n+2.
- IO back-pressure: in LSB_WR, when base[17:16] == IO_SEL and io_buffer_full = 1, the current byte is held. mem_wr = 0, mem_a unchanged, pointer frozen. The byte is written in the first cycle with io_buffer_full = 0.
- rdy_in low:
  - All registers hold; mem_wr is forced to 0.
  - In read states, mem_a shows base + (capture pointer), the oldest uncaptured byte.
  - On the first cycle with rdy_in high, the issue pointer is rewound to the capture pointer, so that byte is re-fetched; no byte is captured in that cycle.
  - RESP does not advance to IDLE while rdy_in is low, and the done pulse is extended to match.
- clear:
  - In IF_RD: go to IDLE at the next edge; if_done is never asserted for the aborted fetch.
  - In RESP with an IF grant: if_done is suppressed.
  - Does not affect LSB_RD, LSB_WR or LSB RESP, since stores and IO loads have side effects.
  - In IDLE: requests sampled in the same cycle as clear are ignored.
- Idle bus: mem_a = 0, mem_wr = 0, mem_dout = 0.
- Address arithmetic: base + i, modulo 2^ADDR_WIDTH.

Test Plan:
- Fetch: if_req with if_addr = 0x100; memory bytes 0x13, 0x05, 0x10, 0x00 -> mem_a shows 0x100..0x103 in consecutive cycles; if_done in T+6 with if_data = 0x00100513.
- Simultaneous requests: if_req and lsb_req (load, byte, addr 0x2000) after reset -> LSB granted first, with lsb_done at T+3. Then IF is granted at the next IDLE. On the next conflict, IF wins.
- IO store with back-pressure: lsb_wr = 1, size = 0, addr = 0x30000, wdata = 0x41, io_buffer_full high for 3 cycles -> mem_wr stays 0 for 3 cycles, then exactly one write of 0x41 to 0x30000, then lsb_done.
- Pause: rdy_in low for 2 cycles during a 4-byte LSB load at 0x400 with bytes 0xEF, 0xBE, 0xAD, 0xDE -> mem_wr stays 0 and no byte is lost or duplicated; lsb_rdata = 0xDEADBEEF.
- Clear: clear pulses during an IF_RD -> IDLE at the next edge and no if_done. Clear during an LSB_WR of a halfword 0xBEEF at 0x10 -> both bytes (0xEF, 0xBE) are written and lsb_done is asserted.
- Reset: rst_in driven low in the middle of LSB_WR -> mem_wr and all outputs are 0 immediately (asynchronously); after release, state is IDLE.
